pe_seq_ctrl: RTL and testbench

- Sequencer for the 8-lane pipelined multiply/adder-tree PE, which has 5 register stages and global `en`/`clr`.
- Computes one neuron output per job:
  - streams `num_chunks` 8-element chunks of inputs/weights from synchronous-read buffers into the PE;
  - tracks in-flight chunks with a valid tag pipe;
  - accumulates the PE partial sums onto a bias;
  - returns the result over a valid/ready handshake.
- Sits between the layer controller (job issue) and the PE plus its input/weight buffers.

---
 rtl/pe_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
`timescale 1ns/1ps
// pe_seq_ctrl
// Sequencer for the 8-lane pipelined multiply/adder-tree PE. Runs one neuron
// per job: streams num_chunks chunk reads from the synchronous-read input and
// weight buffers into the PE, follows the in-flight chunks with a tag pipe,
// sums the PE partial sums onto the bias and hands the result over a
// valid/ready handshake.
//
// Optional build macro: PE_SEQ_CTRL_RELU_EN
//   defined   : result is ReLU(acc) (hidden layers)
//   undefined : result is the raw accumulator (latent mean/log-variance layers)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 job request, sampled only in IDLE
//   num_chunks, bias      job length in chunks and accumulator seed, latched on start
//   busy                  high in FEED or DRAIN
//   chunk_rd, chunk_addr  buffer read strobe and chunk index
//   pe_en, pe_clr         PE global enable and clear
//   pe_out                PE output
//   result, result_valid, result_ready   result handshake
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; result holds last value
// FEED   | one chunk read per cycle, addresses 0..N-1
// DRAIN  | PE pipeline emptying, in-flight chunks still being summed
// DONE   | result_valid high until result_ready
module pe_seq_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   parameter int PE_LAT = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_chunks,
   input  logic [DATA_W-1:0] bias,
   output logic              busy,
   output logic              chunk_rd,
   output logic [ADDR_W-1:0] chunk_addr,
   output logic              pe_en,
   output logic              pe_clr,
   input  logic [DATA_W-1:0] pe_out,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready
);

   localparam int TAG_W = RD_LAT + PE_LAT;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] n_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] acc_d;
   logic [DATA_W-1:0] result_q;
   logic [TAG_W-1:0]  tag_q;
   logic              busy_q;
   logic              rd_q;
   logic              en_q;
   logic              valid_q;
   logic              tag_out;
   logic              last_chunk;
   logic              drain_done;

   function automatic logic [DATA_W-1:0] post_proc(input logic [DATA_W-1:0] v);
`ifdef PE_SEQ_CTRL_RELU_EN
      post_proc = v[DATA_W-1] ? '0 : v;
`else
      post_proc = v;
`endif
   endfunction

   // Tag leaving the pipe marks the cycle pe_out belongs to a real chunk.
   assign tag_out    = tag_q[TAG_W-1];
   assign acc_d      = tag_out ? (acc_q + pe_out) : acc_q;
   assign last_chunk = (addr_q == (n_q - ADDR_ONE));
   // Pipe empties after this cycle's shift: only the outgoing bit may be set.
   assign drain_done = (tag_q[TAG_W-2:0] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         n_q      <= '0;
         addr_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         tag_q    <= '0;
         busy_q   <= 1'b0;
         rd_q     <= 1'b0;
         en_q     <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (en_q) begin
            tag_q <= {tag_q[TAG_W-2:0], rd_q};
         end
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_q   <= num_chunks;
                  acc_q <= bias;
                  if (num_chunks == '0) begin
                     state_q  <= S_DONE;
                     valid_q  <= 1'b1;
                     result_q <= post_proc(bias);
                  end else begin
                     state_q <= S_FEED;
                     busy_q  <= 1'b1;
                     en_q    <= 1'b1;
                     rd_q    <= 1'b1;
                     addr_q  <= '0;
                  end
               end
            end
            S_FEED: begin
               if (last_chunk) begin
                  state_q <= S_DRAIN;
                  rd_q    <= 1'b0;
               end else begin
                  addr_q <= addr_q + ADDR_ONE;
               end
            end
            S_DRAIN: begin
               if (drain_done) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  en_q     <= 1'b0;
                  valid_q  <= 1'b1;
                  result_q <= post_proc(acc_d);
               end
            end
            S_DONE: begin
               if (result_ready) begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b0;
                  addr_q  <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Clear must coincide with the accepted start so the PE is flushed before
   // the first chunk enters; gated by reset so it stays low while aborted.
   assign pe_clr       = rst_n & start & (state_q == S_IDLE);
   assign busy         = busy_q;
   assign chunk_rd     = rd_q;
   assign chunk_addr   = addr_q;
   assign pe_en        = en_q;
   assign result       = result_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
`timescale 1ns/1ps
module tb_pe_seq_ctrl;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] num_chunks = '0;
   logic [DATA_W-1:0] bias = '0;
   logic              busy;
   logic              chunk_rd;
   logic [ADDR_W-1:0] chunk_addr;
   logic              pe_en;
   logic              pe_clr;
   logic [DATA_W-1:0] pe_out = '0;
   logic [DATA_W-1:0] result;
   logic              result_valid;
   logic              result_ready = 1'b0;

   always #5 clk = ~clk;

   pe_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PE_LAT(5), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .num_chunks   (num_chunks),
      .bias         (bias),
      .busy         (busy),
      .chunk_rd     (chunk_rd),
      .chunk_addr   (chunk_addr),
      .pe_en        (pe_en),
      .pe_clr       (pe_clr),
      .pe_out       (pe_out),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc_note = 0;
   logic [DATA_W-1:0] vals [0:127];

   typedef struct {
      int               n;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] pv;
      int               dly;
      logic [DATA_W-1:0] exp_res;
   } vec_t;

   vec_t tbl [0:3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc_note, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] relu_ref(input logic [DATA_W-1:0] v);
`ifdef PE_SEQ_CTRL_RELU_EN
      return ($signed(v) < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Reference: bias plus every chunk value, modulo 2^16, then optional ReLU.
   function automatic logic [DATA_W-1:0] ref_result(input int n, input logic [DATA_W-1:0] b);
      int s;
      s = int'(b);
      for (int i = 0; i < n; i++) s = s + int'(vals[i]);
      return relu_ref(s[DATA_W-1:0]);
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_rd"},     chunk_rd, 0);
      chk({tag, "_addr"},   chunk_addr, 0);
      chk({tag, "_pe_en"},  pe_en, 0);
      chk({tag, "_pe_clr"}, pe_clr, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_valid"},  result_valid, 0);
   endtask

   // One job: start in cycle 0, PE model returns vals[addr] six cycles after
   // each read, garbage otherwise. Checks every output every cycle through the
   // first IDLE cycle after the handshake.
   task automatic run_job(input int n, input logic [DATA_W-1:0] b, input int dly,
                          input logic [DATA_W-1:0] exp_res);
      logic              rdh [0:255];
      logic [ADDR_W-1:0] adh [0:255];
      int v;
      int h;
      logic exp_feed;
      logic exp_busy;
      v = (n == 0) ? 1 : n + 7;
      h = v + dly;
      @(posedge clk); #1;
      cyc_note     = 0;
      start        = 1'b1;
      num_chunks   = ADDR_W'(n);
      bias         = b;
      result_ready = 1'($urandom_range(0, 1));
      pe_out       = DATA_W'($urandom);
      #1;
      chk("pe_clr_start", pe_clr, 1);
      chk("busy_start", busy, 0);
      chk("valid_start", result_valid, 0);
      rdh[0] = 1'b0;
      adh[0] = '0;
      for (int c = 1; c <= h + 1; c++) begin
         @(posedge clk); #1;
         cyc_note     = c;
         start        = (c <= h) ? 1'($urandom_range(0, 1)) : 1'b0;
         num_chunks   = ADDR_W'($urandom);
         bias         = DATA_W'($urandom);
         result_ready = (c < v) ? 1'($urandom_range(0, 1)) : (c >= h);
         if (c >= 6 && rdh[c-6]) pe_out = vals[adh[c-6]];
         else                    pe_out = DATA_W'($urandom);
         #1;
         rdh[c] = chunk_rd;
         adh[c] = chunk_addr;
         exp_feed = (n > 0) && (c <= n);
         exp_busy = (n > 0) && (c <= n + 6);
         chk("chunk_rd", chunk_rd, exp_feed);
         chk("chunk_addr", chunk_addr,
             (c > h) ? 0 : (exp_feed ? c - 1 : ((n > 0) ? n - 1 : 0)));
         chk("busy", busy, exp_busy);
         chk("pe_en", pe_en, exp_busy);
         chk("pe_clr", pe_clr, 0);
         chk("result_valid", result_valid, (c >= v) && (c <= h));
         if (c >= v) chk("result", result, exp_res);
      end
      start        = 1'b0;
      result_ready = 1'b0;
   endtask

   initial begin
      // Reset with random inputs: every output low.
      #2 rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start        = 1'($urandom_range(0, 1));
         num_chunks   = ADDR_W'($urandom);
         bias         = DATA_W'($urandom);
         pe_out       = DATA_W'($urandom);
         result_ready = 1'($urandom_range(0, 1));
         #3;
         chk_all_zero("reset");
      end
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         pe_out = DATA_W'($urandom);
         #1;
         chk("idle_pe_en", pe_en, 0);
         chk("idle_busy", busy, 0);
         chk("idle_valid", result_valid, 0);
         chk("idle_rd", chunk_rd, 0);
      end

      // Directed table: single chunk, long job with backpressure, empty job, wrap.
      tbl[0] = '{1,  16'h0010, 16'h0100, 0, 16'h0110};
      tbl[1] = '{98, 16'h0000, 16'h0001, 5, 16'h0062};
`ifdef PE_SEQ_CTRL_RELU_EN
      tbl[2] = '{0,  16'hFF80, 16'h0000, 0, 16'h0000};
      tbl[3] = '{2,  16'h7FFF, 16'h0001, 1, 16'h0000};
`else
      tbl[2] = '{0,  16'hFF80, 16'h0000, 0, 16'hFF80};
      tbl[3] = '{2,  16'h7FFF, 16'h0001, 1, 16'h8001};
`endif
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 128; i++) vals[i] = tbl[t].pv;
         run_job(tbl[t].n, tbl[t].b, tbl[t].dly, tbl[t].exp_res);
      end

      // Random jobs against the reference sum.
      for (int j = 0; j < 16; j++) begin
         int n;
         int dly;
         logic [DATA_W-1:0] b;
         n   = (j == 15) ? 127 : $urandom_range(0, 40);
         dly = $urandom_range(0, 4);
         b   = DATA_W'($urandom);
         for (int i = 0; i < 128; i++) vals[i] = DATA_W'($urandom);
         run_job(n, b, dly, ref_result(n, b));
      end

      // Abort: ignored start mid-feed, reset mid-job, then a fresh job.
      @(posedge clk); #1;
      cyc_note   = 0;
      start      = 1'b1;
      num_chunks = 7'd10;
      bias       = 16'h1234;
      #1;
      chk("abort_pe_clr_start", pe_clr, 1);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         cyc_note   = c;
         start      = (c == 3);
         num_chunks = 7'd1;
         pe_out     = DATA_W'($urandom);
         #1;
         chk("abort_rd", chunk_rd, 1);
         chk("abort_addr", chunk_addr, c - 1);
         chk("abort_pe_clr", pe_clr, 0);
      end
      @(posedge clk); #1;
      cyc_note = 6;
      start    = 1'b1;
      rst_n    = 1'b0;
      #1;
      chk_all_zero("abort_rst");
      @(posedge clk); #1;
      chk_all_zero("abort_rst_hold");
      start = 1'b0;
      rst_n = 1'b1;
      vals[0] = 16'h0123;
      run_job(1, 16'h0000, 0, relu_ref(16'h0123));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
